// File: rtl/pe_pkg.sv
// Definitions shared between the PE datapath and its operand feeder.
package pe_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_ACC = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // A job needs a non-empty reduction and a slot count the PE can hold.
    function automatic logic cfg_legal(input logic [7:0] k, input logic [3:0] slots,
                                       input logic [3:0] max_slots);
        return (k != 8'd0) && (slots != 4'd0) && (slots <= max_slots);
    endfunction

endpackage

// File: rtl/pe_feeder.sv
// Operand sequencer for the PE: slot-interleaved beats in, rounder returns counted
// back to a job-done pulse.
module pe_feeder #(
    parameter int  para_int_bits  = 7,
    parameter int  para_frac_bits = 9,
    parameter int  NUM_ACC        = 8,
    localparam int DATA_W         = para_int_bits + para_frac_bits
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        cfg_k,
    input  logic [3:0]        cfg_slots,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              op_ready,
    input  logic              pe_rounder_valid,
    output logic [DATA_W-1:0] data_in_1,
    output logic [DATA_W-1:0] data_in_2,
    output logic [3:0]        add_number,
    output logic              rounder_en,
    output logic              keep,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    import pe_pkg::*;

    feeder_state_t     state_q, state_d;
    logic [7:0]        cfg_k_q, cfg_k_d, k_cnt_q, k_cnt_d;
    logic [3:0]        cfg_slots_q, cfg_slots_d, slot_cnt_q, slot_cnt_d;
    logic [3:0]        res_cnt_q, res_cnt_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic [3:0]        add_q, add_d;
    logic              ren_q, ren_d, keep_q, keep_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              accept_s, last_k_s, last_slot_s, start_ok_s;

    assign op_ready    = (state_q == RUN);
    assign accept_s    = op_valid & op_ready;
    assign last_k_s    = (k_cnt_q == (cfg_k_q - 8'd1));
    assign last_slot_s = (slot_cnt_q == (cfg_slots_q - 4'd1));
    assign start_ok_s  = cfg_legal(cfg_k, cfg_slots, 4'(NUM_ACC));

    // Next-state logic: FSM, beat counters and the registered PE port values.
    always_comb begin
        state_d     = state_q;
        cfg_k_d     = cfg_k_q;
        cfg_slots_d = cfg_slots_q;
        k_cnt_d     = k_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        res_cnt_d   = res_cnt_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        add_d       = add_q;
        ren_d       = 1'b0;
        keep_d      = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok_s) begin
                        cfg_k_d     = cfg_k;
                        cfg_slots_d = cfg_slots;
                        k_cnt_d     = 8'd0;
                        slot_cnt_d  = 4'd0;
                        res_cnt_d   = 4'd0;
                        state_d     = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Early rounder returns can land before the last beat is taken.
                res_cnt_d = res_cnt_q + {3'b000, pe_rounder_valid};
                if (accept_s) begin
                    data1_d = op_a;
                    data2_d = op_b;
                    add_d   = slot_cnt_q;
                    keep_d  = 1'b0;
                    ren_d   = last_k_s;
                    if (last_slot_s) begin
                        slot_cnt_d = 4'd0;
                        k_cnt_d    = k_cnt_q + 8'd1;
                        if (last_k_s) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                res_cnt_d = res_cnt_q + {3'b000, pe_rounder_valid};
                if (res_cnt_d == cfg_slots_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_k_q     <= 8'd0;
            cfg_slots_q <= 4'd0;
            k_cnt_q     <= 8'd0;
            slot_cnt_q  <= 4'd0;
            res_cnt_q   <= 4'd0;
            data1_q     <= '0;
            data2_q     <= '0;
            add_q       <= 4'd0;
            ren_q       <= 1'b0;
            keep_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_k_q     <= cfg_k_d;
            cfg_slots_q <= cfg_slots_d;
            k_cnt_q     <= k_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            res_cnt_q   <= res_cnt_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            add_q       <= add_d;
            ren_q       <= ren_d;
            keep_q      <= keep_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_in_1  = data1_q;
    assign data_in_2  = data2_q;
    assign add_number = add_q;
    assign rounder_en = ren_q;
    assign keep       = keep_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a 3-cycle PE return stub and a beat scoreboard.
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        rst, start, op_valid, op_ready, pe_rounder_valid;
    logic [7:0]  cfg_k;
    logic [3:0]  cfg_slots, add_number;
    logic [15:0] op_a, op_b, data_in_1, data_in_2;
    logic        rounder_en, keep, busy, done, cfg_err;
    logic [2:0]  pipe;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  slot;
        logic        ren;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_n, m_k, m_slots;
    logic [15:0] last_a, last_b;
    logic [3:0]  last_add;

    always #5 clk = ~clk;

    // PE stand-in: a rounder_en comes back as pe_rounder_valid three cycles later.
    always @(posedge clk) begin
        if (rst) pipe <= 3'b000;
        else     pipe <= {pipe[1:0], rounder_en};
    end
    assign pe_rounder_valid = pipe[2];

    pe_feeder dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_slots(cfg_slots),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .pe_rounder_valid(pe_rounder_valid), .data_in_1(data_in_1), .data_in_2(data_in_2),
        .add_number(add_number), .rounder_en(rounder_en), .keep(keep), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive a beat (or bubble), then check the PE ports after the edge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b);
        logic  acc;
        beat_t e;
        beat_t g;
        op_valid = v;
        op_a     = a;
        op_b     = b;
        acc      = v && (op_ready === 1'b1);
        if (acc) begin
            e.a    = a;
            e.b    = b;
            e.slot = 4'(m_n % m_slots);
            e.ren  = ((m_n / m_slots) == (m_k - 1));
            m_n++;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (acc) begin
            g = exp_q.pop_front();
            chk("beat_keep", 32'(keep), 32'd0);
            chk("beat_data1", 32'(data_in_1), 32'(g.a));
            chk("beat_data2", 32'(data_in_2), 32'(g.b));
            chk("beat_add_number", 32'(add_number), 32'(g.slot));
            chk("beat_rounder_en", 32'(rounder_en), 32'(g.ren));
            last_a   = g.a;
            last_b   = g.b;
            last_add = g.slot;
        end else begin
            chk("bubble_keep", 32'(keep), 32'd1);
            chk("bubble_rounder_en", 32'(rounder_en), 32'd0);
            chk("bubble_data1", 32'(data_in_1), 32'(last_a));
            chk("bubble_data2", 32'(data_in_2), 32'(last_b));
            chk("bubble_add_number", 32'(add_number), 32'(last_add));
        end
    endtask

    task automatic start_job(input logic [7:0] k, input logic [3:0] slots);
        cfg_k     = k;
        cfg_slots = slots;
        start     = 1'b1;
        m_n       = 0;
        m_k       = int'(k);
        m_slots   = int'(slots);
        cycle(1'b0, 16'h0000, 16'h0000);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_op_ready", 32'(op_ready), 32'd1);
        chk("start_cfg_err", 32'(cfg_err), 32'd0);
    endtask

    task automatic wait_done(input int expected);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 16'h0000, 16'h0000);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("done_latency", 32'(n), 32'(expected));
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, 16'h0000, 16'h0000);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_op_ready", 32'(op_ready), 32'd0);
    endtask

    task automatic chk_reset_values();
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_rounder_en", 32'(rounder_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_keep", 32'(keep), 32'd1);
        chk("rst_data1", 32'(data_in_1), 32'd0);
        chk("rst_data2", 32'(data_in_2), 32'd0);
        chk("rst_add_number", 32'(add_number), 32'd0);
        last_a   = 16'h0000;
        last_b   = 16'h0000;
        last_add = 4'd0;
        exp_q.delete();
    endtask

    task automatic bad_start(input logic [7:0] k, input logic [3:0] slots);
        cfg_k     = k;
        cfg_slots = slots;
        start     = 1'b1;
        cycle(1'b0, 16'h0000, 16'h0000);
        start = 1'b0;
        chk("bad_cfg_err", 32'(cfg_err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_op_ready", 32'(op_ready), 32'd0);
        cycle(1'b1, 16'h1234, 16'h5678);
        chk("bad_cfg_err_pulse", 32'(cfg_err), 32'd0);
        chk("bad_stays_idle", 32'(op_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
        cfg_k = 8'd0; cfg_slots = 4'd0; m_n = 0; m_k = 1; m_slots = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_values();
        rst = 1'b0;

        // k=4, slots=2, back-to-back 1.0 * 2.0 beats.
        start_job(8'd4, 4'd2);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0200, 16'h0400);
        wait_done(4);

        // Same job with a two-cycle gap after the third beat.
        start_job(8'd4, 4'd2);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                cycle(1'b0, 16'hDEAD, 16'hBEEF);
                cycle(1'b0, 16'hDEAD, 16'hBEEF);
            end
            cycle(1'b1, 16'h0A00 + 16'(i), 16'h0500 - 16'(i));
        end
        wait_done(4);

        bad_start(8'd0, 4'd2);
        bad_start(8'd4, 4'd9);
        bad_start(8'd4, 4'd0);

        // Every beat rounds; returns overlap the tail of RUN.
        start_job(8'd1, 4'd8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0100 * 16'(i + 1), 16'h00F0 + 16'(i));
        wait_done(4);

        // Reset in the middle of a job, then a fresh single-slot job.
        start_job(8'd4, 4'd2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h3300 + 16'(i), 16'h4400 + 16'(i));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values();
        start_job(8'd2, 4'd1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 16'h7000 + 16'(i), 16'h0070 + 16'(i));
        wait_done(4);

        // A start pulse during RUN must not disturb the running job.
        start_job(8'd3, 4'd2);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                start = 1'b1; cfg_k = 8'd1; cfg_slots = 4'd1;
            end
            cycle(1'b1, 16'h0C00 + 16'(i), 16'h0D00 + 16'(i));
            start = 1'b0;
            chk("run_start_no_err", 32'(cfg_err), 32'd0);
        end
        wait_done(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
